// File: rtl/input_quant_packer_if.sv
// rtl/input_quant_packer_if.sv - sample stream, threshold config and packed-vector handshake bundle
// master drives samples/config/out_ready; slave is the packer.
interface input_quant_packer_if #(
  parameter int NUM_FEATURES = 49,
  parameter int IN_WIDTH     = 16
);
  localparam int AW = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;

  logic                      in_valid;
  logic                      in_ready;
  logic [IN_WIDTH-1:0]       in_data;
  logic                      in_last;
  logic                      cfg_we;
  logic [AW-1:0]             cfg_addr;
  logic [3*IN_WIDTH-1:0]     cfg_thr;
  logic                      out_valid;
  logic                      out_ready;
  logic [2*NUM_FEATURES-1:0] out_data;
  logic                      frame_err;

  modport master (
    output in_valid, in_data, in_last, cfg_we, cfg_addr, cfg_thr, out_ready,
    input  in_ready, out_valid, out_data, frame_err
  );

  modport slave (
    input  in_valid, in_data, in_last, cfg_we, cfg_addr, cfg_thr, out_ready,
    output in_ready, out_valid, out_data, frame_err
  );
endinterface

// File: rtl/input_quant_packer.sv
// rtl/input_quant_packer.sv - quantizes raw features to 2-bit codes and packs a frame for layer 0
// Per-feature thresholds; code = (x>=t0)+(x>=t1)+(x>=t2).
module input_quant_packer #(
  parameter int NUM_FEATURES = 49,
  parameter int IN_WIDTH     = 16
) (
  input logic                 clk,
  input logic                 rst,
  input_quant_packer_if.slave bus
);
  localparam int              AW       = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;
  localparam int              OW       = 2 * NUM_FEATURES;
  localparam logic [AW-1:0]   LAST_IDX = AW'(NUM_FEATURES - 1);
  localparam logic [AW:0]     NF_LIM   = (AW + 1)'(NUM_FEATURES);

  logic [IN_WIDTH-1:0] r_t0 [NUM_FEATURES];
  logic [IN_WIDTH-1:0] r_t1 [NUM_FEATURES];
  logic [IN_WIDTH-1:0] r_t2 [NUM_FEATURES];
  logic [AW-1:0]       r_idx;
  logic [OW-1:0]       r_asm;
  logic [OW-1:0]       r_out;
  logic                r_out_valid;
  logic                r_frame_err;

  logic                w_at_last;
  logic                w_xfer;
  logic                w_ge0, w_ge1, w_ge2;
  logic [1:0]          w_code;
  logic [OW-1:0]       w_frame;

  assign w_at_last = (r_idx == LAST_IDX);
  // Only the closing sample can overrun an unaccepted output, so only it stalls.
  assign bus.in_ready = !(w_at_last && r_out_valid && !bus.out_ready);
  assign w_xfer    = bus.in_valid && bus.in_ready;

  assign w_ge0  = (bus.in_data >= r_t0[r_idx]);
  assign w_ge1  = (bus.in_data >= r_t1[r_idx]);
  assign w_ge2  = (bus.in_data >= r_t2[r_idx]);
  assign w_code = {1'b0, w_ge0} + {1'b0, w_ge1} + {1'b0, w_ge2};

  always_comb begin
    w_frame = r_asm;
    w_frame[2*r_idx +: 2] = w_code;
  end

  // Registered thresholds give the in-flight sample the pre-write value on a collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_FEATURES; i++) begin
        r_t0[i] <= '1;
        r_t1[i] <= '1;
        r_t2[i] <= '1;
      end
    end else if (bus.cfg_we && ({1'b0, bus.cfg_addr} < NF_LIM)) begin
      r_t0[bus.cfg_addr] <= bus.cfg_thr[IN_WIDTH-1:0];
      r_t1[bus.cfg_addr] <= bus.cfg_thr[2*IN_WIDTH-1:IN_WIDTH];
      r_t2[bus.cfg_addr] <= bus.cfg_thr[3*IN_WIDTH-1:2*IN_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx       <= '0;
      r_asm       <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      if (r_out_valid && bus.out_ready)
        r_out_valid <= 1'b0;
      if (w_xfer) begin
        r_asm <= w_frame;
        if (w_at_last && bus.in_last) begin
          r_out       <= w_frame;
          r_out_valid <= 1'b1;
          r_idx       <= '0;
        end else if (w_at_last || bus.in_last) begin
          r_frame_err <= 1'b1;
          r_idx       <= '0;
        end else begin
          r_idx <= r_idx + AW'(1);
        end
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out;
  assign bus.frame_err = r_frame_err;
endmodule
